// File: rtl/hs_rx_pkg.sv
// Shared constants and width helpers for the handshake receive packer.
package hs_rx_pkg;

  localparam int HS_WIDTH     = 8;
  localparam int HS_BEATS     = 4;
  localparam int HS_DEPTH     = 4;
  localparam int HS_OVF_CNT_W = 8;

  // Width of an index into n entries; never below one bit.
  function automatic int hs_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must reach n inclusive.
  function automatic int hs_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hs_rx_word_fifo.sv
// First-word-fall-through word FIFO with occupancy output; head reads as zero when empty.
module hs_rx_word_fifo
  import hs_rx_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic [W-1:0]                i_wdata,
  input  logic                        i_pop,
  output logic [W-1:0]                o_rdata,
  output logic                        o_valid,
  output logic [hs_cnt_w(DEPTH)-1:0]  o_count
);

  localparam int PTR_W = hs_idx_w(DEPTH);
  localparam int CNT_W = hs_cnt_w(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign o_valid   = (r_count != '0);
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | i_pop);
  assign w_do_pop  = i_pop & o_valid;
  assign o_rdata   = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hs_rx_packer.sv
// Packs synchronizer beats into words (first beat in LSBs) and queues them for a valid/ready sink.
// Build option HS_RX_OVF_CNT_EN adds an 8-bit saturating dropped-beat counter port ovf_cnt.
module hs_rx_packer
  import hs_rx_pkg::*;
#(
  parameter int WIDTH = HS_WIDTH,
  parameter int BEATS = HS_BEATS,
  parameter int DEPTH = HS_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dvalid,
  input  logic [WIDTH-1:0]         dout,
  output logic                     dbusy,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*BEATS-1:0]   out_data,
  output logic                     ovf
`ifdef HS_RX_OVF_CNT_EN
  ,
  output logic [HS_OVF_CNT_W-1:0]  ovf_cnt
`endif
);

  localparam int BCW    = hs_idx_w(BEATS);
  localparam int CNT_W  = hs_cnt_w(DEPTH);
  localparam int PACK_W = WIDTH * (BEATS - 1);

  // Output handshake: a word transfers on every cycle where out_valid and out_ready are both 1;
  // out_valid never depends on out_ready and out_data holds while the word is pending.

  logic [BCW-1:0]    r_beat_cnt;
  logic [PACK_W-1:0] r_pack;
  logic              r_dbusy;
  logic              r_ovf;

  logic             w_last;
  logic             w_full;
  logic             w_pop;
  logic             w_drop;
  logic             w_accept;
  logic             w_push;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_n;
  logic [BCW-1:0]   w_beat_cnt_n;
  logic             w_dbusy_n;

  assign w_last   = (r_beat_cnt == BCW'(BEATS - 1));
  assign w_full   = (w_count == CNT_W'(DEPTH));
  assign w_pop    = out_valid & out_ready;
  // Only a completing beat needs FIFO space; earlier beats always fit in the pack register.
  assign w_drop   = dvalid & ~flush & w_full & w_last & ~w_pop;
  assign w_accept = dvalid & ~flush & ~w_drop;
  assign w_push   = w_accept & w_last;

  always_comb begin
    w_beat_cnt_n = r_beat_cnt;
    if (flush) begin
      w_beat_cnt_n = '0;
    end else if (w_accept) begin
      w_beat_cnt_n = w_last ? '0 : r_beat_cnt + 1'b1;
    end
  end

  always_comb begin
    w_count_n = w_count;
    if (w_push && !w_pop) begin
      w_count_n = w_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_n = w_count - 1'b1;
    end
  end

  // Raised early enough that the one beat already in flight still finds room.
  assign w_dbusy_n = (w_count_n == CNT_W'(DEPTH)) ||
                     ((w_count_n == CNT_W'(DEPTH - 1)) && (w_beat_cnt_n == BCW'(BEATS - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_pack     <= '0;
      r_dbusy    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_beat_cnt <= w_beat_cnt_n;
      r_dbusy    <= w_dbusy_n;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (flush || w_push) begin
        r_pack <= '0;
      end else if (w_accept) begin
        r_pack[int'(r_beat_cnt)*WIDTH +: WIDTH] <= dout;
      end
    end
  end

  hs_rx_word_fifo #(
    .W     (WIDTH * BEATS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({dout, r_pack}),
    .i_pop   (w_pop),
    .o_rdata (out_data),
    .o_valid (out_valid),
    .o_count (w_count)
  );

  assign dbusy = r_dbusy;
  assign ovf   = r_ovf;

`ifdef HS_RX_OVF_CNT_EN
  logic [HS_OVF_CNT_W-1:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != {HS_OVF_CNT_W{1'b1}})) begin
      r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`else
  // Without the counter only the sticky flag records drops.
`endif

endmodule

// File: tb/tb_hs_rx_packer.sv
// Directed bench for hs_rx_packer: packing, back-pressure, drop, flush, full push/pop and reset.
module tb_hs_rx_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        dvalid;
  logic [7:0]  dout;
  logic        dbusy;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        ovf;
`ifdef HS_RX_OVF_CNT_EN
  logic [7:0]  ovf_cnt;
`endif

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pops   = 0;
  int          pops_before;
  logic [31:0] exp_q[$];

  hs_rx_packer #(
    .WIDTH (8),
    .BEATS (4),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dvalid    (dvalid),
    .dout      (dout),
    .dbusy     (dbusy),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf       (ovf)
`ifdef HS_RX_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One clock; a transfer happening on this edge is scored against exp_q first.
  task automatic step();
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_pops++;
      if (exp_q.size() == 0) check("unexpected_pop", out_data, 32'h0);
      else check("pop_data", out_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_beat(input logic [7:0] d);
    dvalid = 1'b1;
    dout   = d;
    step();
    dvalid = 1'b0;
    dout   = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // 16 beats with out_ready low from an empty FIFO and empty pack register.
  task automatic fill(input logic [7:0] base, input string tag);
    int words;
    int cnt;
    for (int i = 0; i < 16; i++) begin
      send_beat(base + 8'(i));
      words = (i + 1) / 4;
      cnt   = (i + 1) % 4;
      if (cnt == 0)
        exp_q.push_back({base + 8'(i), base + 8'(i - 1), base + 8'(i - 2), base + 8'(i - 3)});
      check(tag, dbusy, (words == 4 || (words == 3 && cnt == 3)) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 20 && out_valid; k++) step();
    check("drain_empty", out_valid, 32'd0);
    check("drain_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    dvalid    = 1'b0;
    dout      = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle(2);
    rst = 1'b0;
    check("rst_dbusy", dbusy, 32'd0);
    check("rst_valid", out_valid, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_ovf", ovf, 32'd0);

    // spaced beats, single word
    out_ready = 1'b1;
    send_beat(8'h11); idle(3);
    check("t1_no_valid", out_valid, 32'd0);
    send_beat(8'h22); idle(3);
    send_beat(8'h33); idle(3);
    exp_q.push_back(32'h44332211);
    send_beat(8'h44);
    check("t1_valid", out_valid, 32'd1);
    check("t1_data", out_data, 32'h44332211);
    step();
    check("t1_empty", out_valid, 32'd0);

    // flush, including a beat in the flush cycle
    send_beat(8'hAA);
    send_beat(8'hBB);
    flush = 1'b1; dvalid = 1'b1; dout = 8'hCC;
    step();
    flush = 1'b0; dvalid = 1'b0; dout = 8'h00;
    check("t4_no_valid", out_valid, 32'd0);
    exp_q.push_back(32'h04030201);
    send_beat(8'h01); send_beat(8'h02); send_beat(8'h03); send_beat(8'h04);
    check("t4_valid", out_valid, 32'd1);
    check("t4_data", out_data, 32'h04030201);
    check("t4_ovf", ovf, 32'd0);
    step();
    check("t4_empty", out_valid, 32'd0);

    // back-pressure fill
    out_ready = 1'b0;
    fill(8'h01, "t2_dbusy");
    check("t2_ovf", ovf, 32'd0);
    check("t2_valid", out_valid, 32'd1);
    idle(2);
    check("t2_head_stable", out_data, 32'h04030201);

    // full FIFO, completing beat together with a pop
    send_beat(8'h51); send_beat(8'h52); send_beat(8'h53);
    check("t5_dbusy_full", dbusy, 32'd1);
    out_ready = 1'b1;
    pops_before = n_pops;
    exp_q.push_back(32'h54535251);
    send_beat(8'h54);
    check("t5_dbusy_still_full", dbusy, 32'd1);
    check("t5_ovf", ovf, 32'd0);
    check("t5_head", out_data, 32'h08070605);
    drain();
    check("t5_pop_count", n_pops - pops_before, 32'd5);

    // overflow drop
    out_ready = 1'b0;
    fill(8'h20, "t3_dbusy");
    send_beat(8'hA1); send_beat(8'hA2); send_beat(8'hA3);
    check("t3_dbusy_pre", dbusy, 32'd1);
    check("t3_ovf_pre", ovf, 32'd0);
    send_beat(8'hA4);
    check("t3_ovf", ovf, 32'd1);
`ifdef HS_RX_OVF_CNT_EN
    check("t3_ovf_cnt", ovf_cnt, 32'd1);
`endif
    check("t3_head", out_data, 32'h23222120);
    out_ready = 1'b1;
    step();
    step();
    check("t3_dbusy_clear", dbusy, 32'd0);
    exp_q.push_back(32'hA5A3A2A1);
    send_beat(8'hA5);
    drain();
    check("t3_ovf_sticky", ovf, 32'd1);

    // reset mid-frame
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(8'h61 + 8'(i));
    send_beat(8'h69); send_beat(8'h6A);
    check("t6_pre_valid", out_valid, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("t6_dbusy", dbusy, 32'd0);
    check("t6_valid", out_valid, 32'd0);
    check("t6_data", out_data, 32'd0);
    check("t6_ovf", ovf, 32'd0);
`ifdef HS_RX_OVF_CNT_EN
    check("t6_ovf_cnt", ovf_cnt, 32'd0);
`endif
    out_ready = 1'b1;
    exp_q.push_back(32'h74737271);
    send_beat(8'h71); send_beat(8'h72); send_beat(8'h73); send_beat(8'h74);
    check("t6_word_valid", out_valid, 32'd1);
    check("t6_word", out_data, 32'h74737271);
    step();
    check("t6_empty", out_valid, 32'd0);
    check("t6_queue", exp_q.size(), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
